serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes WIDTH-bit operands in BITS_PER_CYCLE-bit slices, least-significant slice first.
- The carry is held in a flip-flop between slices. It produces sum, carry-out and signed overflow, and a one-cycle done pulse.
- Generalises the single-bit combinational full adder into a clocked, handshaked arithmetic unit. Intended for area-constrained datapaths and as the gate-level reference for later pipelined adders.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 2.
- BITS_PER_CYCLE, 1, slice width processed per clock. Must divide WIDTH exactly; otherwise elaboration fails.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request. Sampled on the rising edge; accepted only in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract. Captured with start.
- A  input  WIDTH  operand A. Captured with start.
- B  input  WIDTH  operand B. Captured with start.
- Ci  input  1  carry-in (add) or borrow-in (sub). Captured with start.
- S  output  WIDTH  result. Held stable from done until the next accepted start.
- Co  output  1  carry-out of the MSB. In sub mode, 1 = no borrow.
- ovf  output  1  two's-complement overflow
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse when S, Co and ovf become valid

Behaviour:
- Reset:
  - state = IDLE.
  - S = 0, Co = 0, ovf = 0, busy = 0, done = 0.
  - Internal operand registers, carry flip-flop and slice counter cleared.
  - Reset during RUN aborts the operation. No done pulse follows.
- N = WIDTH / BITS_PER_CYCLE slices.
- Capture on an accepted start:
  - A_r = A.
  - B_r = sub ? ~B : B.
  - carry = sub ? ~Ci : Ci.
  - slice counter = 0.
  - Next state RUN.
- Arithmetic:
  - sub = 0 computes A + B + Ci.
  - sub = 1 computes A − B − Ci, implemented as A + ~B + ~Ci.
  - All arithmetic is modulo 2^WIDTH.
- State machine:
  - IDLE: busy = 0. start → RUN.
  - RUN:
    - busy = 1.
    - Each edge adds the current slice of A_r and B_r with carry, writes the sum slice into S_r, updates carry and increments the counter.
    - After the edge that processes slice N−1, next state is DONE.
  - DONE:
    - done = 1 and busy = 0 for exactly one cycle.
    - S, Co and ovf are updated on the edge entering DONE.
    - Next edge: start → RUN (back-to-back operation), else → IDLE.
- Latency:
  - Start is sampled at edge k; done is high in the cycle following edge k+N.
  - Throughput is one operation per N+1 cycles.
- Start while in RUN is ignored. Operands are not recaptured and the current operation completes unaffected.
- Outputs and flags:
  - S, Co and ovf keep their last values through IDLE and during a subsequent RUN until the next DONE. They are updated only on entering DONE.
  - Co = final carry out of bit WIDTH−1.
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- The slice counter wraps only via reload on start. It never exceeds N−1.

Decomposition:
- Shared package (arith_pkg):
  - State enumeration IDLE / RUN / DONE.
  - A function for the slice count, WIDTH / BITS_PER_CYCLE.
- One sub-module, full_adder_bit:
  - Single-bit full adder (A, B, Ci → S, Co).
  - BITS_PER_CYCLE instances chained as a ripple inside the slice.
  - The carry into the top instance is exported to compute ovf.

Test Plan:
- WIDTH=8, BPC=1: A=0x0F, B=0x01, Ci=0, sub=0, start at edge 0 → busy high at edges 1–8; done pulse in the cycle after edge 8; S=0x10, Co=0, ovf=0.
- WIDTH=8, BPC=1, two adds:
  - 0xFF+0x01, Ci=0 → S=0x00, Co=1, ovf=0.
  - 0x7F+0x01 → S=0x80, Co=0, ovf=1.
- WIDTH=8, sub=1:
  - 0x05−0x07, Ci=0 → S=0xFE, Co=0, ovf=0.
  - 0x80−0x01 → S=0x7F, Co=1, ovf=1.
- Disturbances:
  - Start re-asserted with new operands mid-RUN → ignored; original result reported.
  - rst asserted mid-RUN → all outputs 0 next cycle, no done pulse.
  - Start held through DONE → second operation begins immediately, done spacing N+1 cycles.
- WIDTH=8, BPC=4: 0xAB+0x55, Ci=1 → done in the cycle after edge 2; S=0x01, Co=1, ovf=0.
- WIDTH=4, BPC ∈ {1, 2, 4}: exhaustive A, B, Ci, sub (1024 cases) → S, Co and ovf match a behavioural model; done latency exactly N.

Source files
------------

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and slice-count helper for serial arithmetic units
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Guarded so a zero slice width reaches the elaboration check instead of dividing by zero.
  function automatic int slice_count(input int width, input int bits_per_cycle);
    return (bits_per_cycle > 0) ? width / bits_per_cycle : 1;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - single-bit full adder, chained as a ripple inside one slice
module full_adder_bit (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle add/subtract, one BITS_PER_CYCLE slice per clock, LSB slice first
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N     = slice_count(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("serial_adder: BITS_PER_CYCLE must divide WIDTH and WIDTH must be at least 2");
  end

  state_t state_q, state_d;
  logic   load, step, last;

  logic [WIDTH-1:0] a_r, b_r, s_r, s_next;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic [BITS_PER_CYCLE-1:0] a_sl, b_sl, sum_sl;
  logic [BITS_PER_CYCLE:0]   c;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last = step && (cnt_q == LAST);
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // s_next is the partial sum with the current slice merged in; on the final slice it is the full result.
  always_comb begin
    int base;
    base   = int'(cnt_q) * BITS_PER_CYCLE;
    a_sl   = a_r[base +: BITS_PER_CYCLE];
    b_sl   = b_r[base +: BITS_PER_CYCLE];
    s_next = s_r;
    s_next[base +: BITS_PER_CYCLE] = sum_sl;
  end

  assign c[0] = carry_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fa
    full_adder_bit u_fa (
      .A  (a_sl[i]),
      .B  (b_sl[i]),
      .Ci (c[i]),
      .S  (sum_sl[i]),
      .Co (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      S       <= '0;
      Co      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        // Subtraction is A + ~B + ~Ci, so the inversion happens once at capture.
        a_r     <= A;
        b_r     <= sub ? ~B : B;
        carry_q <= sub ? ~Ci : Ci;
        cnt_q   <= '0;
      end else if (step) begin
        s_r     <= s_next;
        carry_q <= c[BITS_PER_CYCLE];
        if (!last) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (last) begin
        S   <= s_next;
        Co  <= c[BITS_PER_CYCLE];
        ovf <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
      end
    end
  end

endmodule
